// File: rtl/retire_trace_packer_if.sv
// Retire-trace packer bus: WB-side retire handshake plus packed retire record and status.
// The slave modport is the packer; the master modport is the WB stage / trace consumer side.
// DEPTH must match the packer so fifo_level has the right width.
interface retire_trace_packer_if #(
  parameter int DEPTH = 8
);
  logic                    wb_valid;
  logic                    wb_ready;
  logic [31:0]             wb_pc;
  logic                    wb_rf_en;
  logic [4:0]              wb_rf_waddr;
  logic [31:0]             wb_rf_wdata;
  logic [69:0]             inst_retire;
  logic [31:0]             retire_cnt;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic                    hang;

  modport master (
    output wb_valid, wb_pc, wb_rf_en, wb_rf_waddr, wb_rf_wdata,
    input  wb_ready, inst_retire, retire_cnt, fifo_level, hang
  );

  modport slave (
    input  wb_valid, wb_pc, wb_rf_en, wb_rf_waddr, wb_rf_wdata,
    output wb_ready, inst_retire, retire_cnt, fifo_level, hang
  );
endinterface

// File: rtl/retire_trace_packer.sv
// Retire trace packer: filters WB retires, buffers register writes, emits one 70-bit record per cycle.
// Latency 2 cycles accept-to-visible; wb_ready = !full with no same-cycle pop bypass.
// Optional no-retire watchdog built only when RETIRE_WATCHDOG_EN is defined.
module retire_trace_packer #(
  parameter int DEPTH   = 8,
  parameter int ITLIMIT = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  retire_trace_packer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef logic [69:0] rec_t;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rec_t        mem_q [DEPTH];
  rec_t        inst_retire_q, inst_retire_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic empty, full, accept, push, pop;
  rec_t wb_rec;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign accept = bus.wb_valid && !full;
  // x0 writes and non-writing instructions are counted but never traced
  assign push   = accept && bus.wb_rf_en && (bus.wb_rf_waddr != 5'd0);
  assign pop    = !empty;
  assign wb_rec = {bus.wb_rf_en, bus.wb_rf_waddr, bus.wb_rf_wdata, bus.wb_pc};

  assign bus.wb_ready    = !full;
  assign bus.inst_retire = inst_retire_q;
  assign bus.retire_cnt  = retire_cnt_q;
  assign bus.fifo_level  = wr_ptr_q - rd_ptr_q;

  // Next-state for pointers, output record and retire counter
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    inst_retire_d = '0;
    retire_cnt_d  = retire_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      inst_retire_d = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d      = rd_ptr_q + 1'b1;
    end
    if (accept) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  // Control state; reset drops every buffered record and blanks the retire bus at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inst_retire_q <= '0;
      retire_cnt_q  <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      inst_retire_q <= inst_retire_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  // Record storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wb_rec;
  end

`ifdef RETIRE_WATCHDOG_EN
  localparam int IW = $clog2(ITLIMIT + 1);
  localparam logic [IW-1:0] LIMIT = IW'(ITLIMIT);

  logic [IW-1:0] idle_q, idle_d;
  logic          hang_q, hang_d;

  // Idle counter clears on any accept and saturates at the limit; hang is sticky
  always_comb begin
    idle_d = idle_q;
    if (accept)               idle_d = '0;
    else if (idle_q != LIMIT) idle_d = idle_q + 1'b1;
    hang_d = hang_q || (idle_q == LIMIT);
  end

  // Watchdog state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      hang_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      hang_q <= hang_d;
    end
  end

  assign bus.hang = hang_q;
`else
  assign bus.hang = 1'b0;
`endif
endmodule

// File: tb/tb_retire_trace_packer.sv
// Bench for retire_trace_packer: vector table, scoreboard queue and multi-cycle corner sequences.
module tb_retire_trace_packer;
  localparam int DEPTH   = 8;
  localparam int ITLIMIT = 16;
`ifdef RETIRE_WATCHDOG_EN
  localparam logic EXP_HANG = 1'b1;
`else
  localparam logic EXP_HANG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  retire_trace_packer_if #(.DEPTH(DEPTH)) bus ();

  retire_trace_packer #(.DEPTH(DEPTH), .ITLIMIT(ITLIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        v;
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
    logic [69:0] exp_rec;
    int          exp_inc;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [69:0] mq[$];
  logic [69:0] got_q[$];
  logic [69:0] exp_out;
  logic [31:0] mcnt;
  int          midle;
  logic        mhang;
  int          max_level;

  task automatic check(input string name, input logic [69:0] got, input logic [69:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Drive one cycle of WB stimulus, advance the reference model, then compare after the edge
  task automatic step(input logic v, input logic en, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] pc);
    logic rdy, acc, popf;
    bus.wb_valid    = v;
    bus.wb_rf_en    = en;
    bus.wb_rf_waddr = a;
    bus.wb_rf_wdata = d;
    bus.wb_pc       = pc;
    rdy  = (mq.size() != DEPTH);
    check("wb_ready", 70'(bus.wb_ready), 70'(rdy));
    acc  = v && rdy;
    popf = (mq.size() != 0);
    if (acc && en && (a != 5'd0)) mq.push_back({en, a, d, pc});
    exp_out = popf ? mq.pop_front() : 70'd0;
    if (acc) mcnt = mcnt + 32'd1;
`ifdef RETIRE_WATCHDOG_EN
    if (midle == ITLIMIT) mhang = 1'b1;
    if (acc) midle = 0;
    else if (midle < ITLIMIT) midle++;
`endif
    @(posedge clk);
    #1;
    check("inst_retire", bus.inst_retire, exp_out);
    check("retire_cnt", 70'(bus.retire_cnt), 70'(mcnt));
    check("fifo_level", 70'(bus.fifo_level), 70'(mq.size()));
    check("hang", 70'(bus.hang), 70'(mhang));
    if (mq.size() > max_level) max_level = mq.size();
    if (bus.inst_retire != 70'd0) got_q.push_back(bus.inst_retire);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    vec_t tab[6];
    logic [31:0] cnt0;
    tab[0] = '{1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0000_3000, 70'h25_DEADBEEF_00003000, 1};
    tab[1] = '{1'b1, 1'b1, 5'd0,  32'h1111_2222, 32'h0000_3004, 70'h0, 1};
    tab[2] = '{1'b1, 1'b0, 5'd7,  32'h3333_4444, 32'h0000_3008, 70'h0, 1};
    tab[3] = '{1'b0, 1'b1, 5'd3,  32'h5555_6666, 32'h0000_300C, 70'h0, 0};
    tab[4] = '{1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 70'h3F_FFFFFFFF_FFFFFFFC, 1};
    tab[5] = '{1'b1, 1'b1, 5'd1,  32'h0000_0000, 32'h0000_0004, 70'h21_00000000_00000004, 1};

    rst = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_rf_en = 1'b0; bus.wb_rf_waddr = '0;
    bus.wb_rf_wdata = '0; bus.wb_pc = '0;
    mcnt = '0; midle = 0; mhang = 1'b0; max_level = 0;
    #1;
    check("rst_inst_retire", bus.inst_retire, 70'd0);
    check("rst_retire_cnt", 70'(bus.retire_cnt), 70'd0);
    check("rst_fifo_level", 70'(bus.fifo_level), 70'd0);
    check("rst_hang", 70'(bus.hang), 70'd0);
    check("rst_wb_ready", 70'(bus.wb_ready), 70'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: one retire, then look for its record two cycles after the accept
    for (int i = 0; i < 6; i++) begin
      cnt0 = mcnt;
      step(tab[i].v, tab[i].en, tab[i].a, tab[i].d, tab[i].pc);
      idle();
      check("vec_out", bus.inst_retire, tab[i].exp_rec);
      check("vec_cnt", 70'(bus.retire_cnt), 70'(cnt0 + 32'(tab[i].exp_inc)));
      idle();
      check("vec_cleared", bus.inst_retire, 70'd0);
    end

    // Ten back-to-back retires: all emerge in order, no duplicates or gaps
    got_q.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 5'(i + 1), 32'(i * 3), 32'h1000 + 32'(i * 4));
    repeat (3) idle();
    check("b2b_count", 70'(got_q.size()), 70'd10);
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      check("b2b_pc", 70'(got_q[i][31:0]), 70'(32'h1000 + 32'(i * 4)));

    // Twenty records across pointer wrap, popped every cycle
    got_q.delete();
    max_level = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i), 32'h2000 + 32'(i * 4));
    repeat (3) idle();
    check("wrap_count", 70'(got_q.size()), 70'd20);
    for (int i = 0; i < 20 && i < got_q.size(); i++)
      check("wrap_waddr", 70'(got_q[i][68:64]), 70'(i + 1));
    check("wrap_maxlvl_le2", 70'(max_level <= 2), 70'd1);

    // Random mix of valid/filtered traffic, then drain
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
           $urandom, $urandom);
    repeat (3) idle();
    check("rand_drained", 70'(bus.fifo_level), 70'd0);

    // Reset while records are in flight
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 5'(i + 2), 32'hC0DE_0000 + 32'(i), 32'h4000 + 32'(i * 4));
    bus.wb_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_inst_retire", bus.inst_retire, 70'd0);
    check("midrst_fifo_level", 70'(bus.fifo_level), 70'd0);
    check("midrst_retire_cnt", 70'(bus.retire_cnt), 70'd0);
    mq.delete(); mcnt = '0; midle = 0; mhang = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    repeat (4) idle();
    check("midrst_no_stale", 70'(got_q.size()), 70'd0);

    // Watchdog: long idle stretch, then a retire must not clear hang
    repeat (ITLIMIT + 4) idle();
    check("wd_hang_idle", 70'(bus.hang), 70'(EXP_HANG));
    step(1'b1, 1'b1, 5'd9, 32'h9, 32'h9000);
    idle();
    idle();
    check("wd_hang_sticky", 70'(bus.hang), 70'(EXP_HANG));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
